fix_rx_parser: RTL

//  Receive-side FIX tokenizer between the TOE byte stream and fix_engine's session logic.

---
 rtl/fix_pkg.sv | 17 +
 rtl/fix_ascii_accum.sv | 46 ++++
 rtl/fix_rx_parser.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fix_pkg.sv
// Shared constants, state type and character helper for the FIX receive parser.
package fix_pkg;
  localparam logic [7:0] FIX_SOH        = 8'h01;
  localparam logic [7:0] FIX_EQ         = 8'h3D;
  localparam int         FIX_TAG_BEGIN  = 8;
  localparam int         FIX_TAG_CHKSUM = 10;

  localparam int TAG_W = 17;
  localparam int CHK_W = 10;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {TAG, VALUE, CHKV, DISCARD} fix_rx_state_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction
endpackage

// File: rtl/fix_ascii_accum.sv
// Decimal ASCII accumulator: clear strobe, digit strobe, running value and digit count.
module fix_ascii_accum
  import fix_pkg::*;
#(
  parameter int W  = 17,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          dig_i,
  input  logic [7:0]    char_i,
  output logic [W-1:0]  value_o,
  output logic [CW-1:0] count_o,
  output logic          non_digit_o
);
  logic [W-1:0]  value_q, value_d;
  logic [CW-1:0] count_q, count_d;

  assign non_digit_o = !is_digit(char_i);
  assign value_o     = value_q;
  assign count_o     = count_q;

  always_comb begin
    value_d = value_q;
    count_d = count_q;
    if (clr_i) begin
      value_d = '0;
      count_d = '0;
    end else if (dig_i && !non_digit_o) begin
      // ASCII digits carry their value in the low nibble
      value_d = value_q * W'(10) + W'(char_i[3:0]);
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      value_q <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/fix_rx_parser.sv
// FIX receive tokenizer: tag/value split, value streaming, CheckSum(10) verification, error resync.
module fix_rx_parser
  import fix_pkg::*;
#(
  parameter int NUM_HOST       = 2,
  parameter int MAX_TAG_DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                new_message_i,
  input  logic [7:0]          message_i,
  input  logic [NUM_HOST-1:0] id_i,
  output logic [16:0]         tag_o,
  output logic                tag_valid_o,
  output logic [7:0]          val_o,
  output logic                val_valid_o,
  output logic                field_end_o,
  output logic                msg_done_o,
  output logic                chksum_ok_o,
  output logic                err_o,
  output logic [NUM_HOST-1:0] id_o
);
  // Handshake: new_message_i qualifies message_i/id_i for exactly one cycle; there is no
  // ready, every valid byte is consumed and its results appear registered one cycle later.
  fix_rx_state_t       state_q, state_d;
  logic                expect_q, expect_d;
  logic                resync_q, resync_d;
  logic [7:0]          sum_q, sum_d, snap_q, snap_d;
  logic [NUM_HOST-1:0] id_q, id_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [7:0]          val_q, val_d;
  logic                tag_valid_q, tag_valid_d, val_valid_q, val_valid_d;
  logic                fe_q, fe_d, md_q, md_d, ok_q, ok_d, err_q, err_d;

  logic [TAG_W-1:0] tag_val;
  logic [CHK_W-1:0] chk_val;
  logic [CNT_W-1:0] tag_cnt, chk_cnt;
  logic             tag_nd, chk_nd, tag_dig, chk_dig, err, first_byte, id_bad;

  fix_ascii_accum #(.W(TAG_W), .CW(CNT_W)) u_tag_acc (
    .clk(clk), .rst(rst), .clr_i(new_message_i && !tag_dig), .dig_i(tag_dig),
    .char_i(message_i), .value_o(tag_val), .count_o(tag_cnt), .non_digit_o(tag_nd)
  );

  fix_ascii_accum #(.W(CHK_W), .CW(CNT_W)) u_chk_acc (
    .clk(clk), .rst(rst), .clr_i(new_message_i && !chk_dig), .dig_i(chk_dig),
    .char_i(message_i), .value_o(chk_val), .count_o(chk_cnt), .non_digit_o(chk_nd)
  );

  assign first_byte = expect_q && (state_q == TAG) && (tag_cnt == '0);
  assign id_bad     = !first_byte && (state_q != DISCARD) && (id_i != id_q);

  always_comb begin
    state_d     = state_q;
    expect_d    = expect_q;
    resync_d    = resync_q;
    sum_d       = sum_q;
    snap_d      = snap_q;
    id_d        = id_q;
    tag_d       = tag_q;
    val_d       = val_q;
    tag_valid_d = 1'b0;
    val_valid_d = 1'b0;
    fe_d        = 1'b0;
    md_d        = 1'b0;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    err         = 1'b0;
    tag_dig     = 1'b0;
    chk_dig     = 1'b0;
    if (new_message_i) begin
      sum_d = (first_byte ? 8'd0 : sum_q) + message_i;
      if (first_byte) id_d = id_i;
      if (id_bad) begin
        err = 1'b1;
      end else begin
        case (state_q)
          TAG: begin
            if (!tag_nd) begin
              if (tag_cnt == CNT_W'(MAX_TAG_DIGITS)) err = 1'b1;
              else tag_dig = 1'b1;
            end else if (message_i == FIX_EQ && tag_cnt != '0) begin
              if (expect_q && tag_val != TAG_W'(FIX_TAG_BEGIN)) begin
                err = 1'b1;
              end else begin
                tag_d       = tag_val;
                tag_valid_d = 1'b1;
                expect_d    = 1'b0;
                resync_d    = 1'b0;
                state_d     = (tag_val == TAG_W'(FIX_TAG_CHKSUM)) ? CHKV : VALUE;
              end
            end else begin
              err = 1'b1;
            end
          end
          VALUE: begin
            if (message_i == FIX_SOH) begin
              fe_d    = 1'b1;
              snap_d  = sum_d;
              state_d = TAG;
            end else begin
              val_d       = message_i;
              val_valid_d = 1'b1;
            end
          end
          CHKV: begin
            if (message_i == FIX_SOH) begin
              if (chk_cnt == CNT_W'(3) && chk_val <= CHK_W'(255)) begin
                fe_d     = 1'b1;
                md_d     = 1'b1;
                ok_d     = (chk_val[7:0] == snap_q);
                expect_d = 1'b1;
                state_d  = TAG;
              end else begin
                err = 1'b1;
              end
            end else if (!chk_nd && chk_cnt < CNT_W'(3)) begin
              chk_dig     = 1'b1;
              val_d       = message_i;
              val_valid_d = 1'b1;
            end else begin
              err = 1'b1;
            end
          end
          DISCARD: begin
            if (message_i == FIX_SOH) begin
              expect_d = 1'b1;
              state_d  = TAG;
            end
          end
        endcase
      end
      // While resynchronising, further framing errors are silent until a message begins
      if (err) begin
        err_d    = !resync_q;
        resync_d = 1'b1;
        expect_d = 1'b1;
        state_d  = (message_i == FIX_SOH) ? TAG : DISCARD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= TAG;
      expect_q    <= 1'b1;
      resync_q    <= 1'b0;
      sum_q       <= '0;
      snap_q      <= '0;
      id_q        <= '0;
      tag_q       <= '0;
      val_q       <= '0;
      tag_valid_q <= 1'b0;
      val_valid_q <= 1'b0;
      fe_q        <= 1'b0;
      md_q        <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      expect_q    <= expect_d;
      resync_q    <= resync_d;
      sum_q       <= sum_d;
      snap_q      <= snap_d;
      id_q        <= id_d;
      tag_q       <= tag_d;
      val_q       <= val_d;
      tag_valid_q <= tag_valid_d;
      val_valid_q <= val_valid_d;
      fe_q        <= fe_d;
      md_q        <= md_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
    end
  end

  assign tag_o       = tag_q;
  assign tag_valid_o = tag_valid_q;
  assign val_o       = val_q;
  assign val_valid_o = val_valid_q;
  assign field_end_o = fe_q;
  assign msg_done_o  = md_q;
  assign chksum_ok_o = ok_q;
  assign err_o       = err_q;
  assign id_o        = id_q;
endmodule
